ps2_key_event_unit: RTL
=======================

// Module: ps2_key_event_unit
// PURPOSE
//  PS/2 keyboard front-end and the successor to the single-scan-code display path.
//  - Receives raw ps2_clk/ps2_data frames and decodes the E0 (extended) and F0 (break) prefixes into key events.
//  - Suppresses typematic repeats, counts key presses, and buffers events in a FIFO.
//  - Consumers (seven-segment display, CPU MMIO) read events over a valid/ready port.
// PARAMETERS
//  FIFO_DEPTH   8      event FIFO entries; power of two, >=2
//  CNT_W        16     width of the press counter
//  SYNC_STAGES  2      synchroniser flops on ps2_clk/ps2_data; >=2
//  TIMEOUT_CYC  50000  clk cycles without a ps2_clk fall before a partial frame is aborted
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  ps2_clk    in   1      raw PS/2 clock, asynchronous
//  ps2_data   in   1      raw PS/2 data, asynchronous
//  ev_valid   out  1      FIFO head holds an event
//  ev_ready   in   1      consumer accepts the head this cycle
//  ev_code    out  8      scan code, without prefixes
//  ev_ext     out  1      event was E0-prefixed
//  ev_break   out  1      1 = release, 0 = press
//  ev_ascii   out  8      ASCII of the make code (see CONFIGURATION)
//  press_cnt  out  CNT_W  accepted make events, wraps modulo 2^CNT_W
//  overflow   out  1      sticky: an event was dropped because the FIFO was full
//  frame_err  out  1      sticky: parity, stop-bit or timeout error seen
// BEHAVIOUR
//  Reset: every output 0; FIFO empty; prefix flags, held key, receiver and timeout counter cleared.
//   Reset asserted mid-frame discards the partial frame.
//  Sampling: ps2_clk/ps2_data pass through SYNC_STAGES flops.
//   An edge is a synchronised ps2_clk going 1->0; ps2_data is sampled on that edge only.
//  Receiver FSM (states IDLE, DATA, PARITY, STOP):
//   IDLE: edge with data=0 -> DATA; edge with data=1 -> stays IDLE.
//   DATA: 8 bits, LSB first -> PARITY -> STOP.
//   STOP: data=1 and odd parity over data+parity bits -> byte_valid pulses 1 cycle; otherwise set frame_err, drop the byte.
//   Either way, return to IDLE.
//  Timeout: the counter clears on every edge and in IDLE.
//   Reaching TIMEOUT_CYC-1 outside IDLE -> IDLE, frame_err set, partial byte dropped.
//  Decoder, on each byte_valid:
//   E0 -> ext flag = 1.
//   F0 -> brk flag = 1.
//   Any other byte -> forms event {ext, brk, byte}, then both flags clear.
//  Typematic filter:
//   Held register {valid, ext, code}.
//   A make matching the held key -> suppressed: no event, no count.
//   Any other make -> emitted; held register := this key.
//   A break matching the held key clears the held register; breaks are always emitted.
//  press_cnt increments on every emitted make, including makes dropped by a full FIFO.
//  FIFO:
//   Push accepted when not full, or when full with a pop in the same cycle.
//   A rejected push sets overflow; stored contents stay unchanged.
//   Pop on ev_valid & ev_ready.
//   Push and pop together when empty: the event is pushed, nothing is popped.
//   While empty, ev_code/ev_ext/ev_break/ev_ascii are driven 0.
//  Latency:
//   Stop-bit edge detected in cycle T -> byte_valid in T+1.
//   ev_valid is high in T+2 when the FIFO was empty.
//   ev_* fields are registered outputs.
// CONFIGURATION
//  PS2_ASCII_EN defined:
//   ev_ascii maps non-extended make codes to ASCII: digits 0-9 (16->31 ... 45->30) and letters A-Z uppercase (1C->41 ...).
//   Unmapped, extended or break events -> 8'hFF.
//   The mapping is applied at push time and stored in the FIFO.
//  PS2_ASCII_EN not defined: no ASCII table or storage; ev_ascii tied to 8'hFF while ev_valid, 0 while empty.
// STRUCTURE
//  Package ps2_pkg:
//   - constants PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BRK = 8'hF0, PS2_ASCII_NONE = 8'hFF
//   - typedef ps2_rx_state_e
//   - typedef ps2_event_t, packed {ext, brk, code[7:0], ascii[7:0]}
//  Sub-module ps2_frame_rx: synchroniser, edge detect, receiver FSM and timeout; outputs byte_valid, byte, err.
//  The top level holds the decoder, typematic filter, counter and FIFO.
// TESTING
//  1. Frame 0x16 -> one event: code=16, ext=0, brk=0, ascii=31 (0xFF without PS2_ASCII_EN); press_cnt=1.
//  2. Bytes 16,16,16 then F0,16 -> exactly 2 events: make 16, then break 16; press_cnt=1.
//  3. Bytes E0,75 then E0,F0,75 -> make ext=1 code=75 ascii=FF, then break ext=1 code=75; no stray E0/F0 events.
//  4. Frame 0x1C with bad parity -> no event, frame_err=1; next good frame 0x1C -> event ascii=41.
//  5. ev_ready=0, 9 distinct makes with FIFO_DEPTH=8 -> 8 buffered, overflow=1, press_cnt=9; drained in send order.
//  6. ps2_clk stopped after 4 data bits -> frame_err=1 after TIMEOUT_CYC cycles, then the next frame decodes.
//     reset pulsed mid-frame -> all outputs 0 in the following cycle.

Source files
------------

// File: rtl/ps2_key_event_unit_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg : shared types and constants for the PS/2 key event unit.
//   - PS/2 prefix bytes (E0 extended, F0 break) and the "no ASCII" code.
//   - Receiver FSM state encoding (also exported on the debug port).
//   - Event record carried through the event FIFO.
//   - With PS2_ASCII_EN defined: make-code to ASCII lookup (digits, A-Z).
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_ASCII_NONE = 8'hFF;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } ps2_rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_event_t;

`ifdef PS2_ASCII_EN
  // Scan code set 2 make codes for digits and letters; anything else is
  // reported as PS2_ASCII_NONE.
  function automatic logic [7:0] ps2_make_ascii(input logic [7:0] code);
    case (code)
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
      8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
      8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
      8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
      8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
      8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
      8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
      8'h35: return 8'h59;  8'h1A: return 8'h5A;
      default: return PS2_ASCII_NONE;
    endcase
  endfunction
`endif

endpackage

// File: rtl/ps2_key_event_unit_if.sv
// ---------------------------------------------------------------------------
// ps2_key_event_unit_if : key event read port.
// Handshake: the master holds ev_valid and the ev_* fields stable until the
// slave raises ev_ready; an event transfers on every clock edge where
// ev_valid & ev_ready are both high. ev_ready may be high while ev_valid is
// low (no transfer). Fields are 0 while ev_valid is low.
//   master : ev_valid, ev_code, ev_ext, ev_break, ev_ascii out; ev_ready in
//   slave  : mirror image
// ---------------------------------------------------------------------------
interface ps2_key_event_unit_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
                  input  ev_ready);
  modport slave  (input  ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
                  output ev_ready);
endinterface

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx : PS/2 device-to-host frame receiver.
//   Synchronises ps2_clk/ps2_data, detects ps2_clk falling edges, and
//   shifts in start, 8 data bits (LSB first), odd parity and stop.
//   Ports:
//     clk, reset       system clock, synchronous active-high reset
//     i_ps2_clk/data   raw asynchronous PS/2 lines
//     o_byte_valid     1-cycle pulse, o_byte holds a good byte
//     o_byte           last good byte
//     o_err            1-cycle pulse on parity/stop error or timeout
//     o_state          receiver FSM state (debug)
// ---------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_ps2_clk,
  input  logic          i_ps2_data,
  output logic          o_byte_valid,
  output logic [7:0]    o_byte,
  output logic          o_err,
  output ps2_rx_state_e o_state
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  ps2_rx_state_e          r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_par;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_byte_valid;
  logic [7:0]             r_byte;
  logic                   r_err;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  // Synchronisers reset to the idle-high line level so leaving reset never
  // fakes a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RX_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_err        <= 1'b0;

      if (r_state == RX_IDLE || w_fall) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + 1'b1;

      case (r_state)
        RX_IDLE: begin
          if (w_fall && !w_data_s) begin
            r_state   <= RX_DATA;
            r_bit_cnt <= '0;
          end
        end
        RX_DATA: begin
          if (w_fall) begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= RX_PARITY;
          end
        end
        RX_PARITY: begin
          if (w_fall) begin
            r_par   <= w_data_s;
            r_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_fall) begin
            // Good frame: stop bit high and an odd number of ones over
            // data plus parity.
            if (w_data_s && (^{r_shift, r_par})) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase

      // A stalled ps2_clk abandons the partial frame; an edge in the same
      // cycle restarts the count instead.
      if (r_state != RX_IDLE && !w_fall && r_to_cnt == TO_LAST) begin
        r_state  <= RX_IDLE;
        r_err    <= 1'b1;
        r_to_cnt <= '0;
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_byte;
  assign o_err        = r_err;
  assign o_state      = r_state;

endmodule

// File: rtl/ps2_key_event_unit.sv
// ---------------------------------------------------------------------------
// ps2_key_event_unit : PS/2 keyboard front-end.
//   Frame receiver -> E0/F0 prefix decoder -> typematic repeat filter ->
//   event FIFO -> valid/ready event port.
//   Ports:
//     clk, reset       system clock, synchronous active-high reset
//     ps2_clk/ps2_data raw asynchronous PS/2 lines
//     ev               event port (ps2_key_event_unit_if.master)
//     press_cnt        emitted make events, wraps
//     overflow         sticky: event dropped on a full FIFO
//     frame_err        sticky: parity, stop-bit or timeout error
//     dbg_rx_state     receiver FSM state (debug)
//   Build option: PS2_ASCII_EN adds the make-code ASCII table and stores the
//   ASCII byte in the FIFO; without it ev_ascii reads 8'hFF while valid.
// ---------------------------------------------------------------------------
module ps2_key_event_unit
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  ps2_key_event_unit_if.master   ev,
  output logic [CNT_W-1:0]       press_cnt,
  output logic                   overflow,
  output logic                   frame_err,
  output ps2_rx_state_e          dbg_rx_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int EVT_W = $bits(ps2_event_t);
`ifdef PS2_ASCII_EN
  localparam int EV_W = EVT_W;
`else
  localparam int EV_W = EVT_W - 8;  // {ext, brk, code} only
`endif

  // ---------------- receiver ----------------
  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_rx_err;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_err        (w_rx_err),
    .o_state      (dbg_rx_state)
  );

  // ---------------- decoder + typematic filter ----------------
  logic       r_ext;
  logic       r_brk;
  logic       r_held_valid;
  logic       r_held_ext;
  logic [7:0] r_held_code;

  logic       w_is_key;
  logic       w_held_match;
  logic       w_emit;
  ps2_event_t w_push_ev;

  assign w_is_key     = w_byte_valid && (w_byte != PS2_PREFIX_EXT) &&
                        (w_byte != PS2_PREFIX_BRK);
  assign w_held_match = r_held_valid && (r_held_ext == r_ext) &&
                        (r_held_code == w_byte);
  // Breaks always pass; a make repeating the held key is a typematic repeat.
  assign w_emit       = w_is_key && (r_brk || !w_held_match);

  always_comb begin
    w_push_ev      = '0;
    w_push_ev.ext  = r_ext;
    w_push_ev.brk  = r_brk;
    w_push_ev.code = w_byte;
`ifdef PS2_ASCII_EN
    w_push_ev.ascii = (r_ext || r_brk) ? PS2_ASCII_NONE : ps2_make_ascii(w_byte);
`else
    w_push_ev.ascii = PS2_ASCII_NONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_held_valid <= 1'b0;
      r_held_ext   <= 1'b0;
      r_held_code  <= '0;
    end else if (w_byte_valid) begin
      if (w_byte == PS2_PREFIX_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == PS2_PREFIX_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (!r_brk && !w_held_match) begin
          r_held_valid <= 1'b1;
          r_held_ext   <= r_ext;
          r_held_code  <= w_byte;
        end else if (r_brk && w_held_match) begin
          r_held_valid <= 1'b0;
        end
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [EV_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ev_valid;
  ps2_event_t       r_ev;

  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [PTR_W:0]   w_count_after_pop;
  logic [PTR_W:0]   w_count_next;
  logic [PTR_W-1:0] w_rd_next;
  logic [EV_W-1:0]  w_mem_rd;
  ps2_event_t       w_head_next;

  assign w_pop             = r_ev_valid && ev.ev_ready;
  assign w_full            = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_push_ok         = w_emit && (!w_full || w_pop);
  assign w_count_after_pop = r_count - {{PTR_W{1'b0}}, w_pop};
  assign w_count_next      = w_count_after_pop + {{PTR_W{1'b0}}, w_push_ok};
  assign w_rd_next         = r_rd_ptr + PTR_W'(w_pop);
  assign w_mem_rd          = r_mem[w_rd_next];

  // Next head of queue, so the ev_* fields can be registered. When the
  // FIFO is (or becomes) empty before this push, the head is the new event.
  always_comb begin
    w_head_next = '0;
    if (w_count_next != '0) begin
      if (w_count_after_pop == '0) begin
        w_head_next = w_push_ev;
      end else begin
`ifdef PS2_ASCII_EN
        w_head_next = ps2_event_t'(w_mem_rd);
`else
        w_head_next = ps2_event_t'({w_mem_rd, PS2_ASCII_NONE});
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_ev[EVT_W-1 -: EV_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ev_valid <= 1'b0;
      r_ev       <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_count_next;
      r_ev_valid <= (w_count_next != '0);
      r_ev       <= w_head_next;
    end
  end

  // ---------------- counter and sticky flags ----------------
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_overflow;
  logic             r_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_cnt <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Counted even when the FIFO drops the event.
      if (w_emit && !r_brk)     r_press_cnt <= r_press_cnt + 1'b1;
      if (w_emit && !w_push_ok) r_overflow  <= 1'b1;
      if (w_rx_err)             r_frame_err <= 1'b1;
    end
  end

  assign ev.ev_valid = r_ev_valid;
  assign ev.ev_code  = r_ev.code;
  assign ev.ev_ext   = r_ev.ext;
  assign ev.ev_break = r_ev.brk;
  assign ev.ev_ascii = r_ev.ascii;
  assign press_cnt   = r_press_cnt;
  assign overflow    = r_overflow;
  assign frame_err   = r_frame_err;

endmodule
